// File: rtl/histogram_equalization_sequencer_pkg.sv
// Shared state encoding, derived frame/RAM constants and the watchdog limit
// for the histogram-equalization sequencer.
package histogram_equalization_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CLEAR      = 3'd1,
      ST_WAIT_BLOCK = 3'd2,
      ST_HIST       = 3'd3,
      ST_CDF        = 3'd4,
      ST_EQUALIZE   = 3'd5
   } seq_state_e;

   localparam int WD_WIDTH = 12;
   localparam logic [WD_WIDTH-1:0] WD_LIMIT = 12'd4095;

   function automatic int block_count_f(input int width, input int height, input int table_size);
      return (width * height) / table_size;
   endfunction

   // A frame of a single table still needs a one-bit counter.
   function automatic int count_width_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int ram_depth_f(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/histogram_equalization_sequencer_if.sv
// Handshake and RAM-port bundle between the sequencer (slave) and the
// IDCT/generator/equalizer side plus the histogram RAM (master).
interface histogram_equalization_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 17
);
   logic                  frame_start;
   logic                  block_valid;
   logic                  block_ready;
   logic                  start_histogram;
   logic                  start_CDF;
   logic                  histogram_generated;
   logic                  CDF_generated;
   logic [ADDR_WIDTH-1:0] gen_address;
   logic                  gen_CE;
   logic                  gen_WE;
   logic [DATA_WIDTH-1:0] gen_wdata;
   logic [ADDR_WIDTH-1:0] map_address;
   logic                  map_CE;
   logic                  map_done;
   logic [ADDR_WIDTH-1:0] ram_address;
   logic                  ram_CE;
   logic                  ram_WE;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  equalize_ready;
   logic                  frame_done;
   logic                  seq_error;
   logic                  busy;

   modport slave (
      input  frame_start, block_valid, histogram_generated, CDF_generated,
             gen_address, gen_CE, gen_WE, gen_wdata, map_address, map_CE, map_done,
      output block_ready, start_histogram, start_CDF, ram_address, ram_CE, ram_WE,
             ram_wdata, equalize_ready, frame_done, seq_error, busy
   );

   modport master (
      output frame_start, block_valid, histogram_generated, CDF_generated,
             gen_address, gen_CE, gen_WE, gen_wdata, map_address, map_CE, map_done,
      input  block_ready, start_histogram, start_CDF, ram_address, ram_CE, ram_WE,
             ram_wdata, equalize_ready, frame_done, seq_error, busy
   );

endinterface

// File: rtl/histogram_equalization_sequencer_histogram_ram_mux.sv
// Combinational grant of the single-port histogram RAM to the clear engine,
// the histogram/CDF generator or the equalizer, keyed on sequencer state.
module histogram_ram_mux
   import histogram_equalization_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 17
) (
   input  seq_state_e            state_i,
   input  logic [ADDR_WIDTH-1:0] clear_addr_i,
   input  logic [ADDR_WIDTH-1:0] gen_address_i,
   input  logic                  gen_ce_i,
   input  logic                  gen_we_i,
   input  logic [DATA_WIDTH-1:0] gen_wdata_i,
   input  logic [ADDR_WIDTH-1:0] map_address_i,
   input  logic                  map_ce_i,
   output logic [ADDR_WIDTH-1:0] ram_address_o,
   output logic                  ram_ce_o,
   output logic                  ram_we_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o
);

   always_comb begin
      ram_address_o = '0;
      ram_ce_o      = 1'b0;
      ram_we_o      = 1'b0;
      ram_wdata_o   = '0;
      unique case (state_i)
         ST_CLEAR: begin
            ram_address_o = clear_addr_i;
            ram_ce_o      = 1'b1;
            ram_we_o      = 1'b1;
         end
         ST_HIST, ST_CDF: begin
            ram_address_o = gen_address_i;
            ram_ce_o      = gen_ce_i;
            ram_we_o      = gen_we_i;
            ram_wdata_o   = gen_wdata_i;
         end
         // Equalizer is a read-only client; its write strobe is never honoured.
         ST_EQUALIZE: begin
            ram_address_o = map_address_i;
            ram_ce_o      = map_ce_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/histogram_equalization_sequencer.sv
// Frame sequencer for histogram equalization: clear RAM, one histogram pass per
// table, CDF pass, then equalizer lookups. HIST_SEQ_WATCHDOG_EN adds a HIST/CDF timeout.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   IDLE        | waiting for frame_start
//   CLEAR       | writing zero to every RAM address
//   WAIT_BLOCK  | waiting for the next IDCT table
//   HIST        | generator accumulating one table
//   CDF         | generator building the CDF
//   EQUALIZE    | equalizer owns the RAM read port
module histogram_equalization_sequencer
   import histogram_equalization_sequencer_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240,
   parameter int TABLE_SIZE   = 64,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
   input logic clk,
   input logic rst_n,
   histogram_equalization_sequencer_if.slave bus
);

   localparam int BLOCK_COUNT = block_count_f(IMAGE_WIDTH, IMAGE_HEIGHT, TABLE_SIZE);
   localparam int BC_WIDTH    = count_width_f(BLOCK_COUNT);
   localparam int RAM_DEPTH   = ram_depth_f(ADDR_WIDTH);

   localparam logic [BC_WIDTH-1:0]   LAST_BLOCK = BC_WIDTH'(BLOCK_COUNT - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_DEPTH - 1);

   seq_state_e            state_q;
   logic [ADDR_WIDTH-1:0] clear_addr_q;
   logic [BC_WIDTH-1:0]   block_cnt_q;
   logic                  start_histogram_q;
   logic                  block_ready_q;
   logic                  start_cdf_q;
   logic                  equalize_ready_q;
   logic                  frame_done_q;

`ifdef HIST_SEQ_WATCHDOG_EN
   logic [WD_WIDTH-1:0]   wd_q;
   logic                  seq_error_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= ST_IDLE;
         clear_addr_q      <= '0;
         block_cnt_q       <= '0;
         start_histogram_q <= 1'b0;
         block_ready_q     <= 1'b0;
         start_cdf_q       <= 1'b0;
         equalize_ready_q  <= 1'b0;
         frame_done_q      <= 1'b0;
`ifdef HIST_SEQ_WATCHDOG_EN
         wd_q              <= '0;
         seq_error_q       <= 1'b0;
`endif
      end else begin
         start_histogram_q <= 1'b0;
         block_ready_q     <= 1'b0;
         start_cdf_q       <= 1'b0;
         frame_done_q      <= 1'b0;
`ifdef HIST_SEQ_WATCHDOG_EN
         // Counter falls back to zero whenever it is not explicitly advanced,
         // so every entry into HIST or CDF starts a fresh timeout.
         wd_q              <= '0;
         seq_error_q       <= 1'b0;
`endif
         unique case (state_q)
            ST_IDLE: begin
               if (bus.frame_start) begin
                  state_q      <= ST_CLEAR;
                  clear_addr_q <= '0;
                  block_cnt_q  <= '0;
               end
            end
            ST_CLEAR: begin
               clear_addr_q <= clear_addr_q + 1'b1;
               if (clear_addr_q == LAST_ADDR) begin
                  state_q <= ST_WAIT_BLOCK;
               end
            end
            ST_WAIT_BLOCK: begin
               if (bus.block_valid) begin
                  start_histogram_q <= 1'b1;
                  block_ready_q     <= 1'b1;
                  state_q           <= ST_HIST;
               end
            end
            ST_HIST: begin
               if (bus.histogram_generated) begin
                  if (block_cnt_q == LAST_BLOCK) begin
                     start_cdf_q <= 1'b1;
                     state_q     <= ST_CDF;
                  end else begin
                     block_cnt_q <= block_cnt_q + 1'b1;
                     state_q     <= ST_WAIT_BLOCK;
                  end
               end
`ifdef HIST_SEQ_WATCHDOG_EN
               else if (wd_q == WD_LIMIT - 12'd1) begin
                  seq_error_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            ST_CDF: begin
               if (bus.CDF_generated) begin
                  equalize_ready_q <= 1'b1;
                  state_q          <= ST_EQUALIZE;
               end
`ifdef HIST_SEQ_WATCHDOG_EN
               else if (wd_q == WD_LIMIT - 12'd1) begin
                  seq_error_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            ST_EQUALIZE: begin
               if (bus.map_done) begin
                  equalize_ready_q <= 1'b0;
                  frame_done_q     <= 1'b1;
                  state_q          <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   histogram_ram_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram_mux (
      .state_i       (state_q),
      .clear_addr_i  (clear_addr_q),
      .gen_address_i (bus.gen_address),
      .gen_ce_i      (bus.gen_CE),
      .gen_we_i      (bus.gen_WE),
      .gen_wdata_i   (bus.gen_wdata),
      .map_address_i (bus.map_address),
      .map_ce_i      (bus.map_CE),
      .ram_address_o (bus.ram_address),
      .ram_ce_o      (bus.ram_CE),
      .ram_we_o      (bus.ram_WE),
      .ram_wdata_o   (bus.ram_wdata)
   );

   assign bus.start_histogram = start_histogram_q;
   assign bus.block_ready     = block_ready_q;
   assign bus.start_CDF       = start_cdf_q;
   assign bus.equalize_ready  = equalize_ready_q;
   assign bus.frame_done      = frame_done_q;
   assign bus.busy            = (state_q != ST_IDLE);

`ifdef HIST_SEQ_WATCHDOG_EN
   assign bus.seq_error = seq_error_q;
`else
   assign bus.seq_error = 1'b0;
`endif

endmodule

// File: doc/histogram_equalization_sequencer.md
# histogram_equalization_sequencer

Frame-level controller for the histogram-equalization path. It sits between the IDCT output stage, the histogram generator and the pixel equalizer, and owns the single-port histogram RAM. Per frame it clears the RAM, then starts one histogram pass per decoded 8x8 table and triggers the CDF pass. It then hands the RAM to the equalizer for lookups. All requesters reach the RAM through its multiplexer.

## Interface
- IMAGE_WIDTH, 320, frame width in pixels
- IMAGE_HEIGHT, 240, frame height in pixels
- TABLE_SIZE, 64, pixels per decoded table
- ADDR_WIDTH, 8, histogram RAM address width (PIXEL_WIDTH)
- DATA_WIDTH, 17, histogram RAM data width, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse, begin a frame
- block_valid  in  1  IDCT table ready for histogram
- block_ready  out  1  one-cycle pulse, table accepted
- start_histogram / start_CDF  out  1  one-cycle start pulses to generator
- histogram_generated / CDF_generated  in  1  generator done pulses
- gen_address  in  ADDR_WIDTH; gen_CE, gen_WE  in  1; gen_wdata  in  DATA_WIDTH  generator RAM port
- map_address  in  ADDR_WIDTH; map_CE  in  1  equalizer read port
- map_done  in  1  equalizer finished frame
- ram_address  out  ADDR_WIDTH; ram_CE, ram_WE  out  1; ram_wdata  out  DATA_WIDTH  to RAM (top-level tristate keyed on ram_WE)
- equalize_ready  out  1  level, CDF valid, map port granted
- frame_done  out  1  one-cycle pulse
- seq_error  out  1  one-cycle pulse, see Configuration
- busy  out  1  state != IDLE

## Operation
- BLOCK_COUNT = IMAGE_WIDTH*IMAGE_HEIGHT/TABLE_SIZE (1200 at defaults); block_count width $clog2(BLOCK_COUNT).
- States: IDLE, CLEAR, WAIT_BLOCK, HIST, CDF, EQUALIZE.
- IDLE: frame_start -> CLEAR, clear_addr=0, block_count=0. frame_start in any other state is ignored.
- CLEAR: ram_CE=ram_WE=1, ram_address=clear_addr, ram_wdata=0; clear_addr increments each cycle. Write at 2^ADDR_WIDTH-1 -> WAIT_BLOCK.
- WAIT_BLOCK: block_valid=1 -> register start_histogram=1, block_ready=1, go HIST.
- HIST: on histogram_generated, if block_count==BLOCK_COUNT-1, pulse start_CDF and go CDF. Otherwise increment block_count and go WAIT_BLOCK.
- CDF: CDF_generated -> EQUALIZE; equalize_ready=1 from next cycle.
- EQUALIZE: map_done -> IDLE, frame_done=1, equalize_ready=0.
- RAM mux, combinational:
  - CLEAR: internal clear port.
  - HIST and CDF: gen_* passed through.
  - EQUALIZE: map_address, ram_CE=map_CE, ram_WE=0.
  - IDLE and WAIT_BLOCK: CE=WE=0, address=0, wdata=0.
- Generator or map activity outside its granted state never reaches the RAM.
- histogram_generated/CDF_generated outside HIST/CDF: ignored.

## Timing
- Reset values: all pulse outputs 0, equalize_ready 0, busy 0, state IDLE, counters 0.
- Reset mid-frame returns to IDLE immediately; RAM contents undefined until the next CLEAR.
- All handshake outputs are registered: start_histogram/block_ready appear the cycle after block_valid is sampled in WAIT_BLOCK; start_CDF the cycle after the last histogram_generated.
- CLEAR lasts exactly 2^ADDR_WIDTH cycles (256).
- block_valid held high across a HIST phase is not re-accepted until WAIT_BLOCK.
- Done pulse in the same cycle as the state entry that started it is impossible by construction. No special handling.

## Configuration
- HIST_SEQ_WATCHDOG_EN defined: a 12-bit counter runs in HIST and CDF and resets on each state entry. If it reaches 4095 without the done pulse, seq_error pulses for one cycle and the FSM returns to IDLE.
- Without it: no counter, HIST/CDF wait indefinitely, seq_error tied 0.

## Structure
- Shared package: state encoding localparams, BLOCK_COUNT and RAM_DEPTH derivation, watchdog limit constant.
- One sub-module: histogram_ram_mux (combinational grant/select of clear, generator and map ports, keyed on state).

## Test plan
- IMAGE 16x8 (2 blocks): frame_start -> 256 clear writes of 0 to addresses 0..255. Then 2 start_histogram pulses, 1 start_CDF, equalize_ready after CDF_generated, frame_done after map_done.
- block_valid asserted during HIST -> no second block_ready until histogram_generated seen.
- gen_WE=1 while in EQUALIZE -> ram_WE stays 0; map_address=0x5A in EQUALIZE -> ram_address=0x5A, ram_CE=map_CE.
- frame_start pulsed during WAIT_BLOCK -> ignored; block_count unchanged.
- rst low during CDF -> next cycle all outputs at reset values, busy=0.
- With HIST_SEQ_WATCHDOG_EN, withhold CDF_generated -> seq_error pulse 4095 cycles after CDF entry, state IDLE. Without the macro, still waiting in CDF.
